// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the single-wire LED data receiver.
//   - Default pulse timing constants, in clk cycles at 50 MHz.
//   - Decoded word width (24 bits, G/B/R) and counter width.
//   - Receiver FSM state encoding.
//   - Saturating increment helper for the pulse/low counters.
// No ports (package).
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int WORD_W = 24;
    localparam int CNT_W  = 12;

    // Default timing at 50 MHz (20 ns per clk).
    localparam int T_THRESH_DEF = 30;    // high length at/above which a bit is 1
    localparam int T_MIN_DEF    = 8;     // shortest legal high pulse
    localparam int T_MAX_DEF    = 60;    // longest legal high pulse
    localparam int T_RESET_DEF  = 2500;  // low time that ends a frame (50 us)

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,  // waiting for a full reset-low before trusting the line
        ST_IDLE = 2'd1,  // line is quiet, waiting for the first bit of a frame
        ST_HIGH = 2'd2,  // measuring a high pulse
        ST_LOW  = 2'd3   // between bits, watching for the frame-end low
    } state_e;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk_i   in   destination clock
//   rst_ni  in   asynchronous active-low reset (both flops clear to 0)
//   d_i     in   asynchronous input
//   q_o     out  synchronized output, two clk cycles behind d_i
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/led_signal_rx.sv
// -----------------------------------------------------------------------------
// led_signal_rx
// Receiver for a single-wire pulse-width LED data stream. Each bit is a high
// pulse whose length selects 0/1; 24 bits (MSB first) form one G/B/R word; a
// long low ends the frame. The receiver only starts decoding after it has seen
// a full frame-end low, so it never locks onto the middle of a stream.
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-low reset
//   signal      in   LED data line, asynchronous to clk
//   grb_data    out  [23:0] last delivered word, G[23:16] B[15:8] R[7:0]
//   data_valid  out  one-cycle strobe, grb_data/led_idx valid
//   led_idx     out  [6:0] 0-based index of grb_data within the frame
//   frame_done  out  one-cycle strobe at frame end
//   frame_len   out  [6:0] words delivered in the last frame (held)
//   err         out  one-cycle strobe on a protocol violation
//   overflow    out  sticky until frame end; more than data_num words seen
// -----------------------------------------------------------------------------
module led_signal_rx
    import led_pkg::*;
#(
    parameter int data_num = 32,
    parameter int T_THRESH = T_THRESH_DEF,
    parameter int T_MIN    = T_MIN_DEF,
    parameter int T_MAX    = T_MAX_DEF,
    parameter int T_RESET  = T_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        signal,
    output logic [23:0] grb_data,
    output logic        data_valid,
    output logic [6:0]  led_idx,
    output logic        frame_done,
    output logic [6:0]  frame_len,
    output logic        err,
    output logic        overflow
);

    localparam logic [CNT_W-1:0] TH_C  = 12'(T_THRESH);
    localparam logic [CNT_W-1:0] MIN_C = 12'(T_MIN);
    localparam logic [CNT_W-1:0] MAX_C = 12'(T_MAX);
    localparam logic [CNT_W-1:0] TR_C  = 12'(T_RESET);
    localparam logic [6:0]       DN_C  = 7'(data_num);

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic sig_s;
    logic sig_prev_q;
    logic rise;
    logic fall;

    sync_2ff u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (signal),
        .q_o    (sig_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_prev_q <= 1'b0;
        end else begin
            sig_prev_q <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_prev_q;
    assign fall = ~sig_s & sig_prev_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0]  cnt_lo_q, cnt_lo_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        word_cnt_q, word_cnt_d;
    logic [22:0]       shift_q, shift_d;
    logic [23:0]       grb_q, grb_d;
    logic              dv_q, dv_d;
    logic [6:0]        idx_q, idx_d;
    logic              fd_q, fd_d;
    logic [6:0]        flen_q, flen_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    // Low-time bookkeeping shared by SYNC and LOW: next count and its
    // value clamped at T_RESET so the counter parks there.
    logic [CNT_W-1:0]  lo_inc;
    logic [CNT_W-1:0]  lo_sat;
    logic              lo_done;

    assign lo_inc  = sat_inc(cnt_lo_q);
    assign lo_done = (lo_inc >= TR_C);
    assign lo_sat  = lo_done ? TR_C : lo_inc;

    // The bit just finished is appended below the previously received ones,
    // so the first bit on the wire ends up in bit 23.
    logic              bit_val;
    logic [23:0]       word_w;

    assign bit_val = (cnt_hi_q >= TH_C);
    assign word_w  = {shift_q, bit_val};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (!sig_s && lo_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = (cnt_hi_q < MIN_C) ? ST_SYNC : ST_LOW;
                end else if (cnt_hi_q > MAX_C) begin
                    state_d = ST_SYNC;
                end
            end
            ST_LOW: begin
                // A high level in LOW is always a fresh rising edge, since
                // LOW is entered on a falling edge.
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (lo_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: datapath / output logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_hi_d   = cnt_hi_q;
        cnt_lo_d   = cnt_lo_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        grb_d      = grb_q;
        idx_d      = idx_q;
        flen_d     = flen_q;
        ovf_d      = ovf_q;
        dv_d       = 1'b0;
        fd_d       = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_SYNC: begin
                cnt_lo_d = sig_s ? '0 : lo_sat;
            end

            ST_IDLE: begin
                if (rise) begin
                    cnt_hi_d = '0;
                end
            end

            ST_HIGH: begin
                if (fall) begin
                    cnt_lo_d = '0;
                    if (cnt_hi_q < MIN_C) begin
                        // Runt pulse: drop the whole frame in progress and
                        // resynchronize.
                        err_d      = 1'b1;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end else begin
                        shift_d = word_w[22:0];
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            if (word_cnt_q < DN_C) begin
                                grb_d      = word_w;
                                dv_d       = 1'b1;
                                idx_d      = word_cnt_q;
                                word_cnt_d = word_cnt_q + 7'd1;
                            end else begin
                                // Word count stays parked at data_num.
                                ovf_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (cnt_hi_q > MAX_C) begin
                    // Stuck-high line: abandon the frame.
                    err_d      = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    cnt_lo_d   = '0;
                end else begin
                    cnt_hi_d = sat_inc(cnt_hi_q);
                end
            end

            ST_LOW: begin
                if (rise) begin
                    cnt_hi_d = '0;
                end else begin
                    cnt_lo_d = lo_sat;
                    if (lo_done) begin
                        // Frame end; a partially received word is an error
                        // and is thrown away.
                        err_d      = (bit_cnt_q != 5'd0);
                        bit_cnt_d  = '0;
                        fd_d       = 1'b1;
                        flen_d     = word_cnt_q;
                        word_cnt_d = '0;
                        ovf_d      = 1'b0;
                    end
                end
            end

            default: begin
                cnt_lo_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_hi_q   <= '0;
            cnt_lo_q   <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            grb_q      <= '0;
            dv_q       <= 1'b0;
            idx_q      <= '0;
            fd_q       <= 1'b0;
            flen_q     <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_hi_q   <= cnt_hi_d;
            cnt_lo_q   <= cnt_lo_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            grb_q      <= grb_d;
            dv_q       <= dv_d;
            idx_q      <= idx_d;
            fd_q       <= fd_d;
            flen_q     <= flen_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign grb_data   = grb_q;
    assign data_valid = dv_q;
    assign led_idx    = idx_q;
    assign frame_done = fd_q;
    assign frame_len  = flen_q;
    assign err        = err_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_led_signal_rx.sv
// -----------------------------------------------------------------------------
// tb_led_signal_rx
// Scoreboard bench for led_signal_rx: the stimulus process queues the events
// it expects (word delivered, frame end, error) and a monitor process pops and
// compares each event as the DUT raises it.
// -----------------------------------------------------------------------------
module tb_led_signal_rx;

    localparam logic [1:0] K_DV  = 2'd0;
    localparam logic [1:0] K_FD  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] data;
        logic [6:0]  num;
        logic        errx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sig;
    logic [23:0] grb_data;
    logic        data_valid;
    logic [6:0]  led_idx;
    logic        frame_done;
    logic [6:0]  frame_len;
    logic        err;
    logic        overflow;

    exp_t        q[$];
    exp_t        e;
    logic [1:0]  act_kind;
    int          n_chk;
    int          n_fail;

    // Pulse timing used by send_bit; changed between tests.
    int th1, tl1, th0, tl0;

    led_signal_rx dut (
        .clk        (clk),
        .rst        (rst),
        .signal     (sig),
        .grb_data   (grb_data),
        .data_valid (data_valid),
        .led_idx    (led_idx),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .err        (err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [23:0] d, input logic [6:0] n, input logic ex);
        exp_t x;
        x.kind = k;
        x.data = d;
        x.num  = n;
        x.errx = ex;
        q.push_back(x);
    endtask

    task automatic hold(input logic v, input int n);
        sig = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, th1);
            hold(1'b0, tl1);
        end else begin
            hold(1'b1, th0);
            hold(1'b0, tl0);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int b = 23; b >= 0; b--) begin
            send_bit(w[b]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grb_data"},   32'(grb_data),   32'd0);
        chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        chk({tag, "_led_idx"},    32'(led_idx),    32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_len"},  32'(frame_len),  32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
        chk({tag, "_overflow"},   32'(overflow),   32'd0);
    endtask

    // Monitor: every DUT event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst && (data_valid || frame_done || err)) begin
            act_kind = frame_done ? K_FD : (data_valid ? K_DV : K_ERR);
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got dv=%0b fd=%0b err=%0b idx=%0d data=0x%06h, required no event",
                         data_valid, frame_done, err, led_idx, grb_data);
            end else begin
                e = q.pop_front();
                chk("event_kind", 32'(act_kind), 32'(e.kind));
                if (act_kind == e.kind) begin
                    case (e.kind)
                        K_DV: begin
                            chk("dv_grb_data", 32'(grb_data), 32'(e.data));
                            chk("dv_led_idx",  32'(led_idx),  32'(e.num));
                        end
                        K_FD: begin
                            chk("fd_frame_len",  32'(frame_len),  32'(e.num));
                            chk("fd_err",        32'(err),        32'(e.errx));
                            chk("fd_data_valid", 32'(data_valid), 32'd0);
                        end
                        default: begin
                            chk("err_no_frame_done", 32'(frame_done), 32'd0);
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: got no end of stimulus, required completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        sig    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // Single word with nominal 62-cycle bit period.
        th1 = 40; tl1 = 22; th0 = 20; tl0 = 42;
        hold(1'b0, 2600);
        push(K_DV, 24'hFF0000, 7'd0, 1'b0);
        send_word(24'hFF0000);
        push(K_FD, 24'h0, 7'd1, 1'b0);
        hold(1'b0, 3000);

        // Shorter periods from here on to keep the run compact.
        th1 = 36; tl1 = 6; th0 = 14; tl0 = 6;

        // Full frame of data_num words.
        for (int i = 0; i < 32; i++) begin
            push(K_DV, 24'(i + 1), 7'(i), 1'b0);
            send_word(24'(i + 1));
        end
        chk("overflow_full_frame", 32'(overflow), 32'd0);
        push(K_FD, 24'h0, 7'd32, 1'b0);
        hold(1'b0, 3000);

        // One word too many.
        for (int i = 0; i < 33; i++) begin
            if (i < 32) push(K_DV, 24'(i + 1), 7'(i), 1'b0);
            send_word(24'(i + 1));
            if (i == 31) chk("overflow_before_extra", 32'(overflow), 32'd0);
        end
        chk("overflow_after_extra", 32'(overflow), 32'd1);
        push(K_FD, 24'h0, 7'd32, 1'b0);
        hold(1'b0, 3000);
        chk("overflow_cleared_at_frame_end", 32'(overflow), 32'd0);

        // Partial word at frame end.
        for (int b = 0; b < 10; b++) send_bit(b[0]);
        push(K_FD, 24'h0, 7'd0, 1'b1);
        hold(1'b0, 3000);

        // Runt glitch mid-word, then an ignored word, then recovery.
        for (int b = 0; b < 5; b++) send_bit(b[1]);
        push(K_ERR, 24'h0, 7'd0, 1'b1);
        hold(1'b1, 4);
        hold(1'b0, 6);
        send_word(24'h00FF00);
        hold(1'b0, 3000);
        push(K_DV, 24'h123456, 7'd0, 1'b0);
        send_word(24'h123456);
        push(K_FD, 24'h0, 7'd1, 1'b0);
        hold(1'b0, 3000);

        // Reset during bit 12.
        for (int b = 0; b < 11; b++) send_bit(1'b1);
        sig = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("midword_reset");
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        hold(1'b1, 20);
        hold(1'b0, 6);
        send_word(24'hC3C3C3);
        send_word(24'h3C3C3C);
        send_word(24'hFFFFFF);
        hold(1'b0, 3000);
        push(K_DV, 24'hA5A5A5, 7'd0, 1'b0);
        send_word(24'hA5A5A5);
        push(K_FD, 24'h0, 7'd1, 1'b0);
        hold(1'b0, 3000);

        hold(1'b0, 10);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_signal_rx.md
LED_SIGNAL_RX -- requirements
Module: led_signal_rx

Interface
REQ-001 Parameter data_num, default 32, is the maximum number of 24-bit words accepted per frame (range 1..127).
REQ-002 Parameter T_THRESH, default 30, is the high-pulse length in clk cycles at or above which a bit decodes as 1.
REQ-003 Parameter T_MIN, default 8, is the shortest legal high pulse in clk cycles.
REQ-004 Parameter T_MAX, default 60, is the longest legal high pulse in clk cycles.
REQ-005 Parameter T_RESET, default 2500, is the low time in clk cycles that ends a frame (50 us at 50 MHz).
REQ-006 clk  input  1  single clock for the whole block; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 signal  input  1  single-wire pulse-width LED data line, asynchronous to clk.
REQ-009 grb_data  output  24  last decoded word, G[23:16] B[15:8] R[7:0], MSB first on the wire.
REQ-010 data_valid  output  1  one-cycle strobe; grb_data and led_idx are valid in that cycle.
REQ-011 led_idx  output  7  index of the word in grb_data within the current frame, 0-based.
REQ-012 frame_done  output  1  one-cycle strobe at frame end.
REQ-013 frame_len  output  7  number of words delivered in the frame just ended; valid with frame_done and held afterwards.
REQ-014 err  output  1  one-cycle strobe on any protocol violation.
REQ-015 overflow  output  1  sticky flag; set when more than data_num words arrive in one frame.

Function
REQ-016 signal passes a 2-flop synchronizer; all edge detection uses the synchronized value; pin-to-decision latency is 3 clk cycles.
REQ-017 FSM states: SYNC, IDLE, HIGH, LOW.
REQ-018 SYNC: count consecutive low cycles; a high resets the count; on reaching T_RESET, go to IDLE with no frame_done; a frame never starts mid-stream.
REQ-019 IDLE: on a rising edge, clear the high counter and go to HIGH.
REQ-020 HIGH: on a falling edge, evaluate the count: below T_MIN, err, discard the partial word, go to SYNC; otherwise shift in bit (count >= T_THRESH) and go to LOW.
REQ-021 HIGH: when the count exceeds T_MAX while still high, err, go to SYNC.
REQ-022 On the 24th bit, the cycle after the falling edge: grb_data updated, data_valid=1, led_idx = current word count; then the word count increments and the bit count clears.
REQ-023 Words with index >= data_num are not delivered (no data_valid); overflow is set instead; the word count saturates at data_num.
REQ-024 LOW: a rising edge goes to HIGH; when the low count reaches T_RESET, end the frame.
REQ-025 Frame end: if bit count is nonzero, err and discard the partial word; frame_done=1; frame_len = delivered words; word count clears; overflow clears; go to IDLE.
REQ-026 A frame with zero delivered words still raises frame_done, with frame_len=0.
REQ-027 Counters are 12 bits and saturate, never wrap; the low counter stops at T_RESET.
REQ-028 err and frame_done may assert in the same cycle (partial word at frame end); data_valid never coincides with frame_done.

Reset
REQ-029 While rst=0: state=SYNC, counters=0, grb_data=0, led_idx=0, frame_len=0, and data_valid, frame_done, err and overflow are all 0.
REQ-030 Reset asserted mid-word discards all partial data; after release, the block requires a full T_RESET low before decoding.

Structure
REQ-031 Shared package led_pkg holds the default timing constants (T_THRESH, T_MIN, T_MAX, T_RESET at 50 MHz), the word width of 24, and the FSM state enum.
REQ-032 One sub-module, sync_2ff (2-flop synchronizer with async active-low reset), is instantiated for signal; all else is inline.

Verification
REQ-033 After reset, hold signal low 2600 cycles, then send 0xFF0000 (T1H=40, T0H=20, period 62), then low 3000 -> data_valid once with grb_data=0xFF0000, led_idx=0, then frame_done with frame_len=1.
REQ-034 Send 32 words 0x000001..0x000020, then low 3000 -> 32 data_valid strobes with led_idx 0..31 and matching data, frame_len=32, overflow=0.
REQ-035 Send 33 words with data_num=32 -> 32 strobes, overflow=1 until frame_done, frame_len=32.
REQ-036 Send 10 bits, then low 3000 -> err and frame_done in the same cycle, frame_len=0, no data_valid.
REQ-037 Inject a 4-cycle high glitch mid-word -> err; the following word is ignored until a 2500-cycle low; the next frame decodes correctly.
REQ-038 Assert rst during bit 12 -> all outputs 0 immediately; after release, words sent without a preceding 2500-cycle low produce no data_valid.
